// File: rtl/wired_alu_arb_if.sv
// Request/response bundle between the issue queues, the shared-ALU arbiter and
// writeback. The slave modport is the arbiter's view.
interface wired_alu_arb_if #(
  parameter int REQ_NUM = 4,
  parameter int TAG_W   = 6
);
  localparam int ID_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]             req_valid_i;
  logic [REQ_NUM-1:0]             req_ready_o;
  logic [REQ_NUM-1:0][31:0]       req_r0_i;
  logic [REQ_NUM-1:0][31:0]       req_r1_i;
  logic [REQ_NUM-1:0][31:0]       req_pc_i;
  logic [REQ_NUM-1:0][1:0]        req_grand_op_i;
  logic [REQ_NUM-1:0][1:0]        req_op_i;
  logic [REQ_NUM-1:0][TAG_W-1:0]  req_tag_i;

  logic                           resp_valid_o;
  logic                           resp_ready_i;
  logic [31:0]                    resp_res_o;
  logic [TAG_W-1:0]               resp_tag_o;
  logic [ID_W-1:0]                resp_id_o;

  modport master (
    output req_valid_i, req_r0_i, req_r1_i, req_pc_i, req_grand_op_i, req_op_i,
           req_tag_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_res_o, resp_tag_o, resp_id_o
  );

  modport slave (
    input  req_valid_i, req_r0_i, req_r1_i, req_pc_i, req_grand_op_i, req_op_i,
           req_tag_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_res_o, resp_tag_o, resp_id_o
  );
endinterface

// File: rtl/wired_alu_arb.sv
// Round-robin sharing of one combinational ALU among REQ_NUM requesters through a
// single operand stage. Define WIRED_ALU_ARB_PERF_EN for issue/stall counters.
module wired_alu_arb #(
  parameter int REQ_NUM = 4,
  parameter int TAG_W   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  wired_alu_arb_if.slave bus_if,
  output logic [31:0]    alu_r0_o,
  output logic [31:0]    alu_r1_o,
  output logic [31:0]    alu_pc_o,
  output logic [1:0]     alu_grand_op_o,
  output logic [1:0]     alu_op_o,
  input  logic [31:0]    alu_res_i
`ifdef WIRED_ALU_ARB_PERF_EN
  ,
  output logic [31:0]    perf_issue_o,
  output logic [31:0]    perf_stall_o
`endif
);
  localparam int ID_W = $clog2(REQ_NUM);

  logic [ID_W-1:0]    rr_q, rr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [31:0]        s1_r0_q, s1_r0_d;
  logic [31:0]        s1_r1_q, s1_r1_d;
  logic [31:0]        s1_pc_q, s1_pc_d;
  logic [1:0]         s1_grand_op_q, s1_grand_op_d;
  logic [1:0]         s1_op_q, s1_op_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;

  logic [REQ_NUM-1:0] hi_mask;
  logic [REQ_NUM-1:0] masked;
  logic [REQ_NUM-1:0] pick_src;
  logic [REQ_NUM-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               any_req;
  logic               can_accept;
  logic               accept;

  // Requesters at or above rr_q get first pick; fall back to the full set on wrap.
  assign hi_mask  = ~((REQ_NUM'(1) << rr_q) - REQ_NUM'(1));
  assign masked   = bus_if.req_valid_i & hi_mask;
  assign pick_src = (|masked) ? masked : bus_if.req_valid_i;
  assign any_req  = |bus_if.req_valid_i;

  always_comb begin
    win_idx = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (pick_src[k]) begin
        win_idx = ID_W'(k);
      end
    end
  end

  // rst_n gates acceptance so nobody sees a handshake while the stage is held in reset.
  assign can_accept = rst_n & (~s1_valid_q | bus_if.resp_ready_i) & ~flush_i;
  assign accept     = any_req & can_accept;

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_grant
    assign grant[gi]              = any_req & (win_idx == ID_W'(gi));
    assign bus_if.req_ready_o[gi] = grant[gi] & can_accept;
  end

  always_comb begin
    rr_d          = rr_q;
    s1_valid_d    = s1_valid_q;
    s1_r0_d       = s1_r0_q;
    s1_r1_d       = s1_r1_q;
    s1_pc_d       = s1_pc_q;
    s1_grand_op_d = s1_grand_op_q;
    s1_op_d       = s1_op_q;
    s1_tag_d      = s1_tag_q;
    s1_id_d       = s1_id_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d    = 1'b1;
      s1_r0_d       = bus_if.req_r0_i[win_idx];
      s1_r1_d       = bus_if.req_r1_i[win_idx];
      s1_pc_d       = bus_if.req_pc_i[win_idx];
      s1_grand_op_d = bus_if.req_grand_op_i[win_idx];
      s1_op_d       = bus_if.req_op_i[win_idx];
      s1_tag_d      = bus_if.req_tag_i[win_idx];
      s1_id_d       = win_idx;
      rr_d          = (win_idx == ID_W'(REQ_NUM - 1)) ? '0 : win_idx + ID_W'(1);
    end else if (bus_if.resp_ready_i) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q          <= '0;
      s1_valid_q    <= 1'b0;
      s1_r0_q       <= '0;
      s1_r1_q       <= '0;
      s1_pc_q       <= '0;
      s1_grand_op_q <= '0;
      s1_op_q       <= '0;
      s1_tag_q      <= '0;
      s1_id_q       <= '0;
    end else begin
      rr_q          <= rr_d;
      s1_valid_q    <= s1_valid_d;
      s1_r0_q       <= s1_r0_d;
      s1_r1_q       <= s1_r1_d;
      s1_pc_q       <= s1_pc_d;
      s1_grand_op_q <= s1_grand_op_d;
      s1_op_q       <= s1_op_d;
      s1_tag_q      <= s1_tag_d;
      s1_id_q       <= s1_id_d;
    end
  end

  assign alu_r0_o       = s1_r0_q;
  assign alu_r1_o       = s1_r1_q;
  assign alu_pc_o       = s1_pc_q;
  assign alu_grand_op_o = s1_grand_op_q;
  assign alu_op_o       = s1_op_q;

  assign bus_if.resp_valid_o = s1_valid_q;
  assign bus_if.resp_res_o   = alu_res_i;
  assign bus_if.resp_tag_o   = s1_tag_q;
  assign bus_if.resp_id_o    = s1_id_q;

`ifdef WIRED_ALU_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (accept) begin
      perf_issue_d = perf_issue_q + 32'd1;
    end
    if (any_req & ~can_accept & ~flush_i) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
